// File: rtl/speed_scheduler_if.sv
// Bundle of frame/player status inputs and speed outputs for speed_scheduler.
// The game-side controller drives through master; the scheduler itself uses slave.
interface speed_scheduler_if;
   logic       frame_tick_in;
   logic       game_active_in;
   logic       crash_in;
   logic       airborne_in;
   logic       ducking_in;
   logic [3:0] speed_out;
   logic [1:0] level_out;
   logic       pending_out;
   logic       change_out;

   modport master (
      output frame_tick_in, game_active_in, crash_in, airborne_in, ducking_in,
      input  speed_out, level_out, pending_out, change_out
   );

   modport slave (
      input  frame_tick_in, game_active_in, crash_in, airborne_in, ducking_in,
      output speed_out, level_out, pending_out, change_out
   );
endinterface

// File: rtl/speed_scheduler.sv
// Game speed sequencer: counts frames during a run and steps the speed code 1->2->4->8,
// deferring each step to a grounded, non-ducking frame so physics never changes mid-move.
module speed_scheduler #(
   parameter int FRAMES_PER_LEVEL = 1800,
   parameter int MAX_LEVEL        = 3
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   speed_scheduler_if.slave  bus
);

   localparam int              CW       = $clog2(FRAMES_PER_LEVEL);
   localparam logic [CW-1:0]   CNT_LAST = CW'(FRAMES_PER_LEVEL - 1);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]   CNT_ZERO = '0;
   localparam logic [1:0]      LVL_MAX  = 2'(MAX_LEVEL);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_PENDING = 2'd2,
      S_HALT    = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [1:0]    r_level;
   logic [1:0]    w_level_nxt;
   logic [3:0]    r_speed;
   logic          r_pending;
   logic          r_change;
   logic          w_step;
   logic          w_safe;
   logic          w_tick;

   assign w_safe = !bus.airborne_in && !bus.ducking_in;
   assign w_tick = bus.frame_tick_in;

   // Next-state, frame counter and level decisions; crash beats inactivity beats ticks.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_level_nxt = r_level;
      w_step      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt   = CNT_ZERO;
            w_level_nxt = 2'd0;
            if (bus.game_active_in && !bus.crash_in) begin
               w_state_nxt = S_RUN;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_RUN, S_PENDING: begin
            if (bus.crash_in) begin
               w_state_nxt = S_HALT;
               w_cnt_nxt   = CNT_ZERO;
               w_level_nxt = 2'd0;
            end else if (!bus.game_active_in) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = CNT_ZERO;
               w_level_nxt = 2'd0;
            end else if (r_state == S_PENDING) begin
               w_cnt_nxt = CNT_ZERO;
               if (w_tick && w_safe) begin
                  w_step      = 1'b1;
                  w_level_nxt = r_level + 2'd1;
                  w_state_nxt = S_RUN;
               end else begin
                  w_state_nxt = S_PENDING;
               end
            end else if (w_tick) begin
               if (r_cnt < CNT_LAST) begin
                  w_cnt_nxt = r_cnt + CNT_ONE;
               end else if (r_level < LVL_MAX) begin
                  w_cnt_nxt = CNT_ZERO;
                  if (w_safe) begin
                     w_step      = 1'b1;
                     w_level_nxt = r_level + 2'd1;
                  end else begin
                     w_state_nxt = S_PENDING;
                  end
               end else begin
                  // Top level reached: hold the counter at its last value, never step.
                  w_cnt_nxt = CNT_LAST;
               end
            end else begin
               w_state_nxt = S_RUN;
            end
         end
         S_HALT: begin
            w_cnt_nxt   = CNT_ZERO;
            w_level_nxt = 2'd0;
            if (!bus.game_active_in) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_HALT;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = CNT_ZERO;
            w_level_nxt = 2'd0;
         end
      endcase
   end

   // State, counter and registered outputs; level and speed code update together.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state   <= S_IDLE;
         r_cnt     <= CNT_ZERO;
         r_level   <= 2'd0;
         r_speed   <= 4'd1;
         r_pending <= 1'b0;
         r_change  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_level   <= w_level_nxt;
         r_speed   <= 4'd1 << w_level_nxt;
         r_pending <= (w_state_nxt == S_PENDING);
         r_change  <= w_step;
      end
   end

   assign bus.speed_out   = r_speed;
   assign bus.level_out   = r_level;
   assign bus.pending_out = r_pending;
   assign bus.change_out  = r_change;

endmodule
